// File: rtl/round_timer_pkg.sv
// Shared types and BCD helpers for the round timer controller.
package round_timer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StPause,
        StStopped,
        StExpired
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned BONUS_SECS = 5;
    localparam logic [7:0]  BCD_MAX    = 8'h99;

    // Caller guarantees v != 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0) begin
            return {v[7:4], v[3:0] - 4'd1};
        end
        return {v[7:4] - 4'd1, 4'd9};
    endfunction

    function automatic logic [7:0] bcd_add_sat(input logic [7:0] v, input logic [3:0] n);
        logic [7:0] s;
        s = 8'(v[7:4]) * 8'd10 + 8'(v[3:0]) + 8'(n);
        if (s > 8'd99) begin
            return BCD_MAX;
        end
        return {4'(s / 8'd10), 4'(s % 8'd10)};
    endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Game-side signal bundle of the round timer; add_bonus exists only with ROUND_TIMER_BONUS_EN.
interface round_timer_ctrl_if;
    logic start;
    logic pause;
    logic answer_done;
    logic one_sec_tick;
`ifdef ROUND_TIMER_BONUS_EN
    logic add_bonus;
`endif
    logic tick_en;
    logic tick_clr;
    logic running;
    logic warn;
    logic time_up;
    logic expired;
    round_timer_pkg::bcd_digit_t tens;
    round_timer_pkg::bcd_digit_t ones;

    modport master (
`ifdef ROUND_TIMER_BONUS_EN
        output add_bonus,
`endif
        output start, pause, answer_done, one_sec_tick,
        input  tick_en, tick_clr, tens, ones, running, warn, time_up, expired
    );

    modport slave (
`ifdef ROUND_TIMER_BONUS_EN
        input  add_bonus,
`endif
        input  start, pause, answer_done, one_sec_tick,
        output tick_en, tick_clr, tens, ones, running, warn, time_up, expired
    );
endinterface

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD counter: load, decrement (stops at 00), saturating bonus add, zero flag.
module bcd_down_counter2 import round_timer_pkg::*; #(
    parameter logic [7:0] INIT = 8'h30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    input  logic       add,
    output logic [7:0] value,
    output logic [7:0] next_val,
    output logic       zero
);

    logic [7:0] cnt_q;

    assign value = cnt_q;
    assign zero  = (cnt_q == 8'h00);

    // A simultaneous decrement folds into the add so the net step is BONUS_SECS - 1.
    always_comb begin
        next_val = cnt_q;
        if (load) begin
            next_val = load_val;
        end else if (add) begin
            next_val = bcd_add_sat(cnt_q, dec ? 4'(BONUS_SECS - 1) : 4'(BONUS_SECS));
        end else if (dec && !zero) begin
            next_val = bcd_dec(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= next_val;
        end
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// Round timer FSM: gates/clears the tick source and counts down the BCD seconds.
// Optional bonus input enabled by defining ROUND_TIMER_BONUS_EN.
module round_timer_ctrl import round_timer_pkg::*; #(
    parameter logic [3:0] START_TENS = 4'd3,
    parameter logic [3:0] START_ONES = 4'd0,
    parameter logic [7:0] WARN_SECS  = 8'h05
) (
    input logic               clk,
    input logic               reset,
    round_timer_ctrl_if.slave bus
);

    localparam logic [7:0] START_VAL = {START_TENS, START_ONES};

    if (START_TENS > 4'd9 || START_ONES > 4'd9 ||
        WARN_SECS[7:4] > 4'd9 || WARN_SECS[3:0] > 4'd9) begin : g_param_check
        $error("round_timer_ctrl: BCD parameter digit greater than 9");
    end

    state_e     state_q, state_d;
    logic       load, dec, add, bonus;
    logic [7:0] cnt, cnt_next;
    logic       cnt_zero;
    logic       tick_en_q, tick_clr_q, running_q, warn_q, time_up_q, expired_q;

`ifdef ROUND_TIMER_BONUS_EN
    assign bonus = bus.add_bonus;
`else
    assign bonus = 1'b0;
`endif

    bcd_down_counter2 #(
        .INIT(START_VAL)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .load_val(START_VAL),
        .dec     (dec),
        .add     (add),
        .value   (cnt),
        .next_val(cnt_next),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        dec     = 1'b0;
        add     = 1'b0;
        unique case (state_q)
            StIdle, StStopped, StExpired: begin
                if (bus.start) begin
                    state_d = StLoad;
                    load    = 1'b1;
                end
            end
            // The counter already holds the start value here.
            StLoad: state_d = cnt_zero ? StExpired : StRun;
            StRun, StPause: begin
                if (bus.start) begin
                    state_d = StLoad;
                    load    = 1'b1;
                end else if (bus.answer_done) begin
                    state_d = StStopped;
                end else begin
                    dec = (state_q == StRun) && bus.one_sec_tick;
                    add = bonus;
                    if (dec && !bonus && cnt == 8'h01) begin
                        state_d = StExpired;
                    end else begin
                        state_d = bus.pause ? StPause : StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_en_q  <= 1'b0;
            tick_clr_q <= 1'b0;
            running_q  <= 1'b0;
            warn_q     <= 1'b0;
            time_up_q  <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_en_q  <= (state_d == StRun);
            tick_clr_q <= (state_d == StLoad);
            running_q  <= (state_d == StRun);
            warn_q     <= (state_d == StRun || state_d == StPause) &&
                          (cnt_next <= WARN_SECS) && (cnt_next != 8'h00);
            time_up_q  <= (state_d == StExpired) && (state_q != StExpired);
            expired_q  <= (state_d == StExpired);
        end
    end

    assign bus.tens     = cnt[7:4];
    assign bus.ones     = cnt[3:0];
    assign bus.tick_en  = tick_en_q;
    assign bus.tick_clr = tick_clr_q;
    assign bus.running  = running_q;
    assign bus.warn     = warn_q;
    assign bus.time_up  = time_up_q;
    assign bus.expired  = expired_q;

endmodule
